ir_link_arbiter: RTL and testbench
==================================

# ir_link_arbiter

Controller that shares the single IR transmitter between two word-level requesters and sequences the half-duplex link. It sits between the requesters and the `ir_transceiver`. It grants one requester at a time and launches the transmitter with a one-cycle `tx_start`. It tracks `tx_busy` through the frame and holds the receiver disabled for the whole transmit plus a guard interval, so the receiver does not capture its own echo.

## Interface
- `GUARD_CYCLES`, 16: cycles `rx_enable` stays low after `tx_busy` falls; 0 = no guard.
- `START_TIMEOUT`, 8: cycles allowed for `tx_busy` to rise after `tx_start`; must be ≥1.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req0` / `req1`  in  1  requester wants to send; held until its `done`/`fail` pulse.
- `data0` / `data1`  in  32  word to send; stable while the matching `req` is high.
- `done0` / `done1`  out  1  one-cycle pulse: word sent (`tx_busy` completed).
- `fail0` / `fail1`  out  1  one-cycle pulse: `tx_busy` never rose within `START_TIMEOUT`.
- `rx_allow`  in  1  host request to enable reception.
- `rx_enable`  out  1  to receiver: `rx_allow` AND state==IDLE (registered).
- `tx_data`  out  32  to transmitter; loaded at grant, held until next grant.
- `tx_start`  out  1  to transmitter; one-cycle pulse.
- `tx_busy`  in  1  from transmitter.
- `busy`  out  1  high in any state other than IDLE.
- `owner`  out  1  index of the last granted requester.

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE, GUARD.
- IDLE: sample `req0`/`req1`.
  - Only one high: grant it.
  - Both high: grant the one ≠ `owner` (round-robin).
  - On grant: `tx_data` ← `dataN`; `owner` ← N; `tx_start` ← 1; counter ← 0; go to WAIT_BUSY.
- WAIT_BUSY:
  - `tx_busy`=1: go to WAIT_DONE.
  - Else, counter == `START_TIMEOUT`-1: pulse `failN`, go to IDLE (no guard).
  - Else: counter+1.
- WAIT_DONE: on `tx_busy`=0, pulse `doneN`.
  - `GUARD_CYCLES`=0: go to IDLE.
  - Otherwise: counter ← `GUARD_CYCLES`-1, go to GUARD.
- GUARD: counter reaches 0 → IDLE; else counter-1.
- Requester handshake:
  - `req` is sampled only in IDLE.
  - A requester that keeps `req` high after `done` re-enters arbitration on the next IDLE cycle.
  - `dataN` changes while not granted are ignored.
- Counter width: `$clog2(max(GUARD_CYCLES, START_TIMEOUT)+1)`. The counter never wraps; state exits occur at the terminal values.
- `tx_busy` glitches after WAIT_DONE exits are ignored until the next grant.

## Timing
- Reset values:
  - `tx_start`, `done*`, `fail*`, `busy`, `rx_enable`: 0.
  - `tx_data`: 0.
  - `owner`: 1, so `req0` wins the first tie.
  - State: IDLE.
- Grant latency: `req` high at edge k → `tx_start`=1, `busy`=1, `rx_enable`=0 after edge k. `tx_start` returns to 0 after edge k+1.
- Completion: `tx_busy` sampled 0 in WAIT_DONE at edge m → `doneN`=1 for cycle m..m+1.
  - `busy` and `rx_enable` stay low through `GUARD_CYCLES` further cycles.
  - `rx_enable` follows `rx_allow` from the first IDLE cycle (registered, 1-cycle lag).
- Timeout: `failN` is asserted `START_TIMEOUT` cycles after the `tx_start` cycle.
- Back-to-back: the minimum gap between `doneN` and the next `tx_start` is `GUARD_CYCLES`+1 cycles.
- Reset mid-operation:
  - All outputs go to reset values immediately (async).
  - No `done`/`fail` is issued for the aborted word.
  - A transmitter that is still busy is left to finish; the arbiter returns to IDLE.

## Configuration
- `IR_ARB_FIXED_PRIO_EN` defined: arbitration is fixed priority; `req0` always wins when both are high. `owner` still reports the last grant.
- Undefined (default): round-robin as above.

## Test plan
- Single send:
  - Stimulus: `req0`=1, `data0`=0xA5A5_0001; transmitter model raises `tx_busy` 2 cycles after `tx_start` and holds it for 10 cycles.
  - Required: one `tx_start` pulse; `tx_data`=0xA5A5_0001; `done0` pulse; `rx_enable` low from grant until 16 cycles after `tx_busy` falls, then follows `rx_allow`=1.
- Contention:
  - Stimulus: `req0` and `req1` held high; `data0`=0x1, `data1`=0x2.
  - Required (default build): grants alternate 0,1,0,1; `tx_data` sequence 0x1, 0x2, 0x1, 0x2; `done` pulses alternate accordingly.
- Timeout:
  - Stimulus: `req1`=1; `tx_busy` held 0.
  - Required: `fail1` pulses exactly 8 cycles after `tx_start`; no `done1`; next cycle IDLE with `rx_enable`=`rx_allow`.
- Reset in WAIT_DONE:
  - Stimulus: assert `reset` mid-frame.
  - Required: all outputs 0, `owner`=1; after release with `req0`=`req1`=1, `req0` is granted first.
- `GUARD_CYCLES`=0:
  - Required: IDLE and `rx_enable` are restored the cycle after `done`; the next grant follows at the earliest 1 cycle after `done`.
- `IR_ARB_FIXED_PRIO_EN` defined, both `req` held high:
  - Required: only requester 0 is granted; `owner` stays 0.

Source files
------------

// File: rtl/ir_link_arbiter.sv
// Shares one IR transmitter between two requesters and sequences the half-duplex link.
// Define IR_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties); default is round-robin.
module ir_link_arbiter #(
  parameter int GUARD_CYCLES  = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [31:0] data0_i,
  input  logic [31:0] data1_i,
  output logic        done0_o,
  output logic        done1_o,
  output logic        fail0_o,
  output logic        fail1_o,
  input  logic        rx_allow_i,
  output logic        rx_enable_o,
  output logic [31:0] tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  output logic        busy_o,
  output logic        owner_o
);

  localparam int CNT_MAX = (GUARD_CYCLES > START_TIMEOUT) ? GUARD_CYCLES : START_TIMEOUT;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] GUARD_LAST   = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam bit HAS_GUARD = (GUARD_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GUARD     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   tx_data_q, tx_data_d;
  logic          owner_q, owner_d;
  logic          tx_start_q, tx_start_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          fail0_q, fail0_d;
  logic          fail1_q, fail1_d;
  logic          rx_enable_q, rx_enable_d;
  logic          grant_sel;

  // Winner when at least one request is present; only meaningful in IDLE.
  always_comb begin
`ifdef IR_ARB_FIXED_PRIO_EN
    grant_sel = ~req0_i;
`else
    grant_sel = (req0_i && req1_i) ? ~owner_q : req1_i;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    tx_start_d = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    fail0_d    = 1'b0;
    fail1_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          tx_data_d  = grant_sel ? data1_i : data0_i;
          owner_d    = grant_sel;
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fail0_d = ~owner_q;
          fail1_d = owner_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy_i) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
          if (HAS_GUARD) begin
            cnt_d   = GUARD_LAST;
            state_d = S_GUARD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GUARD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Looks at the next state so the receiver is cut off in the same cycle as tx_start.
    rx_enable_d = rx_allow_i && (state_d == S_IDLE);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      owner_q     <= 1'b1;
      tx_start_q  <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      fail0_q     <= 1'b0;
      fail1_q     <= 1'b0;
      rx_enable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      owner_q     <= owner_d;
      tx_start_q  <= tx_start_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      fail0_q     <= fail0_d;
      fail1_q     <= fail1_d;
      rx_enable_q <= rx_enable_d;
    end
  end

  assign done0_o     = done0_q;
  assign done1_o     = done1_q;
  assign fail0_o     = fail0_q;
  assign fail1_o     = fail1_q;
  assign rx_enable_o = rx_enable_q;
  assign tx_data_o   = tx_data_q;
  assign tx_start_o  = tx_start_q;
  assign busy_o      = (state_q != S_IDLE);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_ir_link_arbiter.sv
// Self-checking bench for ir_link_arbiter: default instance (guard 16) and a zero-guard instance.
module tb_ir_link_arbiter;

  localparam int GUARD_A = 16;
  localparam int TOUT    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, rx_allow;
  logic [31:0] data0, data1;
  logic        tx_busy_a, tx_busy_b;

  logic        done0_a, done1_a, fail0_a, fail1_a, rx_enable_a, tx_start_a, busy_a, owner_a;
  logic [31:0] tx_data_a;
  logic        done0_b, done1_b, fail0_b, fail1_b, rx_enable_b, tx_start_b, busy_b, owner_b;
  logic [31:0] tx_data_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural transmitter: busy rises xm_lat cycles after tx_start and lasts xm_len cycles.
  bit xm_en  = 1'b0;
  bit xm_sel = 1'b0;
  int xm_lat = 2;
  int xm_len = 10;
  int rise_at = 0;
  int fall_at = 0;

  always #5 clk = ~clk;

  ir_link_arbiter #(.GUARD_CYCLES(GUARD_A), .START_TIMEOUT(TOUT)) dut_a (
    .clock_i(clk), .reset_i(rst), .req0_i(req0), .req1_i(req1),
    .data0_i(data0), .data1_i(data1), .done0_o(done0_a), .done1_o(done1_a),
    .fail0_o(fail0_a), .fail1_o(fail1_a), .rx_allow_i(rx_allow), .rx_enable_o(rx_enable_a),
    .tx_data_o(tx_data_a), .tx_start_o(tx_start_a), .tx_busy_i(tx_busy_a),
    .busy_o(busy_a), .owner_o(owner_a)
  );

  ir_link_arbiter #(.GUARD_CYCLES(0), .START_TIMEOUT(TOUT)) dut_b (
    .clock_i(clk), .reset_i(rst), .req0_i(req0), .req1_i(req1),
    .data0_i(data0), .data1_i(data1), .done0_o(done0_b), .done1_o(done1_b),
    .fail0_o(fail0_b), .fail1_o(fail1_b), .rx_allow_i(rx_allow), .rx_enable_o(rx_enable_b),
    .tx_data_o(tx_data_b), .tx_start_o(tx_start_b), .tx_busy_i(tx_busy_b),
    .busy_o(busy_b), .owner_o(owner_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (xm_en && ((!xm_sel && tx_start_a) || (xm_sel && tx_start_b))) begin
      rise_at = cyc + xm_lat;
      fall_at = rise_at + xm_len;
    end
    tx_busy_a = xm_en && !xm_sel && (cyc >= rise_at) && (cyc < fall_at);
    tx_busy_b = xm_en && xm_sel && (cyc >= rise_at) && (cyc < fall_at);
  endtask

  task automatic do_reset();
    rst = 1'b1; xm_en = 1'b0; req0 = 1'b0; req1 = 1'b0;
    rise_at = 0; fall_at = 0; tx_busy_a = 1'b0; tx_busy_b = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rx_allow = 1'b1;
    data0 = '0; data1 = '0; tx_busy_a = 1'b0; tx_busy_b = 1'b0;
    #2;
    checks++;
    if ({tx_start_a, done0_a, done1_a, fail0_a, fail1_a, busy_a, rx_enable_a} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl_a: got %b want 0000000",
               {tx_start_a, done0_a, done1_a, fail0_a, fail1_a, busy_a, rx_enable_a});
    end
    checks++;
    if (tx_data_a !== 32'h0) begin errors++; $display("FAIL reset_txdata_a: got %h want 0", tx_data_a); end
    checks++;
    if (owner_a !== 1'b1) begin errors++; $display("FAIL reset_owner_a: got %b want 1", owner_a); end
    checks++;
    if ({tx_start_b, done0_b, done1_b, fail0_b, fail1_b, busy_b, rx_enable_b} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl_b: got %b want 0000000",
               {tx_start_b, done0_b, done1_b, fail0_b, fail1_b, busy_b, rx_enable_b});
    end
    checks++;
    if (owner_b !== 1'b1) begin errors++; $display("FAIL reset_owner_b: got %b want 1", owner_b); end
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (rx_enable_a !== 1'b1) begin errors++; $display("FAIL reset_rx_follow: got %b want 1", rx_enable_a); end
    $display("reset: outputs checked, rx_enable=%b after release", rx_enable_a);
  endtask

  task automatic test_single_send();
    int start_c, done_c, n_start, n_done, req_c;
    logic exp_rx;
    do_reset();
    rx_allow = 1'b1; xm_en = 1'b1; xm_sel = 1'b0; xm_lat = 2; xm_len = 10;
    data0 = 32'hA5A5_0001; data1 = 32'hDEAD_BEEF; req0 = 1'b1;
    req_c = cyc; start_c = -1; done_c = -1; n_start = 0; n_done = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx_start_a) begin
        n_start++; start_c = cyc;
        $display("single: tx_start cyc=%0d owner=%0d data=%h", cyc, owner_a, tx_data_a);
        checks++;
        if (cyc !== req_c + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", cyc, req_c + 1); end
        checks++;
        if (tx_data_a !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data: got %h want a5a50001", tx_data_a); end
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy_a); end
      end
      if (done0_a) begin
        n_done++; done_c = cyc; req0 = 1'b0;
        $display("single: done0 cyc=%0d", cyc);
        checks++;
        if (cyc !== fall_at + 1) begin errors++; $display("FAIL single_done_time: got %0d want %0d", cyc, fall_at + 1); end
      end
      if (start_c < 0) exp_rx = 1'b1;
      else if (done_c < 0 || cyc < done_c + GUARD_A) exp_rx = 1'b0;
      else exp_rx = 1'b1;
      checks++;
      if (rx_enable_a !== exp_rx) begin
        errors++; $display("FAIL single_rx_enable cyc=%0d: got %b want %b", cyc, rx_enable_a, exp_rx);
      end
      checks++;
      if ({done1_a, fail0_a, fail1_a} !== 3'b000) begin
        errors++; $display("FAIL single_spurious cyc=%0d: got %b want 000", cyc, {done1_a, fail0_a, fail1_a});
      end
    end
    checks++;
    if (n_start !== 1) begin errors++; $display("FAIL single_start_count: got %0d want 1", n_start); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", n_done); end
    checks++;
    if (tx_data_a !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data_hold: got %h want a5a50001", tx_data_a); end
  endtask

  task automatic test_contention();
    int n_done, next_ok, cur;
    bit in_frame;
    logic model_owner, g;
    logic [1:0] exp_done;
    do_reset();
    rx_allow = 1'b1; xm_en = 1'b1; xm_sel = 1'b0;
    xm_lat = $urandom_range(0, 3); xm_len = $urandom_range(1, 6);
    data0 = 32'h1; data1 = 32'h2; req0 = 1'b1; req1 = 1'b1;
    model_owner = 1'b1; n_done = 0; next_ok = cyc + 1; in_frame = 1'b0; cur = 0;
    for (int i = 0; i < 300 && n_done < 4; i++) begin
      step();
      if (tx_start_a) begin
`ifdef IR_ARB_FIXED_PRIO_EN
        g = 1'b0;
`else
        g = ~model_owner;
`endif
        $display("contend: tx_start cyc=%0d owner=%0d data=%h", cyc, owner_a, tx_data_a);
        checks++;
        if (owner_a !== g) begin errors++; $display("FAIL contend_owner: got %b want %b", owner_a, g); end
        checks++;
        if (tx_data_a !== (g ? 32'h2 : 32'h1)) begin
          errors++; $display("FAIL contend_data: got %h want %h", tx_data_a, g ? 32'h2 : 32'h1);
        end
        checks++;
        if (cyc !== next_ok) begin errors++; $display("FAIL contend_start_time: got %0d want %0d", cyc, next_ok); end
        model_owner = g; cur = int'(g); in_frame = 1'b1;
        xm_lat = $urandom_range(0, 3); xm_len = $urandom_range(1, 6);
      end
      exp_done = 2'b00;
      if (in_frame && cyc == fall_at + 1) exp_done[cur] = 1'b1;
      checks++;
      if ({done1_a, done0_a} !== exp_done) begin
        errors++; $display("FAIL contend_done cyc=%0d: got %b want %b", cyc, {done1_a, done0_a}, exp_done);
      end
      if (exp_done != 2'b00) begin
        in_frame = 1'b0; n_done++; next_ok = cyc + GUARD_A + 1;
        $display("contend: done%0d cyc=%0d", cur, cyc);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL contend_guard_busy: got %b want 1", busy_a); end
      end
      checks++;
      if ({fail0_a, fail1_a} !== 2'b00) begin errors++; $display("FAIL contend_fail: got %b want 00", {fail0_a, fail1_a}); end
    end
    checks++;
    if (n_done !== 4) begin errors++; $display("FAIL contend_frames: got %0d want 4", n_done); end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_timeout();
    int start_c, n_start;
    do_reset();
    xm_en = 1'b0; rx_allow = 1'($urandom_range(0, 1)); data1 = $urandom;
    req1 = 1'b1; start_c = -1; n_start = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_start_a) begin
        n_start++; start_c = cyc;
        $display("timeout: tx_start cyc=%0d owner=%0d data=%h", cyc, owner_a, tx_data_a);
        checks++;
        if (owner_a !== 1'b1) begin errors++; $display("FAIL timeout_owner: got %b want 1", owner_a); end
      end
      checks++;
      if (fail1_a !== (start_c >= 0 && cyc == start_c + TOUT)) begin
        errors++; $display("FAIL timeout_fail1 cyc=%0d: got %b want %b", cyc, fail1_a, start_c >= 0 && cyc == start_c + TOUT);
      end
      checks++;
      if ({done0_a, done1_a, fail0_a} !== 3'b000) begin
        errors++; $display("FAIL timeout_spurious: got %b want 000", {done0_a, done1_a, fail0_a});
      end
      if (start_c >= 0 && cyc < start_c + TOUT) begin
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL timeout_busy cyc=%0d: got %b want 1", cyc, busy_a); end
      end
      if (start_c >= 0 && (cyc == start_c + TOUT || cyc == start_c + TOUT + 1)) begin
        if (cyc == start_c + TOUT) $display("timeout: fail1 cyc=%0d", cyc);
        req1 = 1'b0;
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %b want 0", busy_a); end
        checks++;
        if (rx_enable_a !== rx_allow) begin errors++; $display("FAIL timeout_rx: got %b want %b", rx_enable_a, rx_allow); end
      end
    end
    checks++;
    if (n_start !== 1) begin errors++; $display("FAIL timeout_starts: got %0d want 1", n_start); end
  endtask

  task automatic test_reset_mid();
    int start_c, rel_c;
    bit seen;
    do_reset();
    rx_allow = 1'b1; xm_en = 1'b1; xm_sel = 1'b0; xm_lat = 1; xm_len = 30;
    data0 = 32'h1111_0000; data1 = 32'h2222_0000; req0 = 1'b1; start_c = -1;
    for (int i = 0; i < 10 && start_c < 0; i++) begin
      step();
      if (tx_start_a) start_c = cyc;
    end
    req1 = 1'b1;
    while (cyc < start_c + 6) step();
    #2 rst = 1'b1;
    #1;
    $display("reset_mid: reset asserted cyc=%0d owner was 0", cyc);
    checks++;
    if ({tx_start_a, done0_a, done1_a, fail0_a, fail1_a, busy_a, rx_enable_a} !== 7'b0) begin
      errors++; $display("FAIL midreset_ctrl: got %b want 0000000",
                         {tx_start_a, done0_a, done1_a, fail0_a, fail1_a, busy_a, rx_enable_a});
    end
    checks++;
    if (tx_data_a !== 32'h0) begin errors++; $display("FAIL midreset_txdata: got %h want 0", tx_data_a); end
    checks++;
    if (owner_a !== 1'b1) begin errors++; $display("FAIL midreset_owner: got %b want 1", owner_a); end
    step();
    rst = 1'b0; rel_c = cyc; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (tx_start_a) begin
        seen = 1'b1;
        $display("reset_mid: tx_start cyc=%0d owner=%0d data=%h", cyc, owner_a, tx_data_a);
        checks++;
        if (owner_a !== 1'b0) begin errors++; $display("FAIL midreset_first_grant: got %b want 0", owner_a); end
        checks++;
        if (tx_data_a !== 32'h1111_0000) begin errors++; $display("FAIL midreset_data: got %h want 11110000", tx_data_a); end
        checks++;
        if (cyc !== rel_c + 1) begin errors++; $display("FAIL midreset_latency: got %0d want %0d", cyc, rel_c + 1); end
      end else begin
        checks++;
        if ({done0_a, done1_a, fail0_a, fail1_a} !== 4'b0) begin
          errors++; $display("FAIL midreset_no_done: got %b want 0000", {done0_a, done1_a, fail0_a, fail1_a});
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midreset_regrant: got none want tx_start"); end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_guard_zero();
    int n_done, next_ok, cur;
    bit in_frame;
    logic model_owner, g;
    logic [1:0] exp_done;
    do_reset();
    rx_allow = 1'b1; xm_en = 1'b1; xm_sel = 1'b1;
    xm_lat = $urandom_range(0, 2); xm_len = $urandom_range(1, 4);
    data0 = 32'h3; data1 = 32'h4; req0 = 1'b1; req1 = 1'b1;
    model_owner = 1'b1; n_done = 0; next_ok = cyc + 1; in_frame = 1'b0; cur = 0;
    for (int i = 0; i < 100 && n_done < 3; i++) begin
      step();
      if (tx_start_b) begin
`ifdef IR_ARB_FIXED_PRIO_EN
        g = 1'b0;
`else
        g = ~model_owner;
`endif
        $display("guard0: tx_start cyc=%0d owner=%0d data=%h", cyc, owner_b, tx_data_b);
        checks++;
        if (owner_b !== g) begin errors++; $display("FAIL guard0_owner: got %b want %b", owner_b, g); end
        checks++;
        if (tx_data_b !== (g ? 32'h4 : 32'h3)) begin
          errors++; $display("FAIL guard0_data: got %h want %h", tx_data_b, g ? 32'h4 : 32'h3);
        end
        checks++;
        if (cyc !== next_ok) begin errors++; $display("FAIL guard0_start_time: got %0d want %0d", cyc, next_ok); end
        model_owner = g; cur = int'(g); in_frame = 1'b1;
        xm_lat = $urandom_range(0, 2); xm_len = $urandom_range(1, 4);
      end
      exp_done = 2'b00;
      if (in_frame && cyc == fall_at + 1) exp_done[cur] = 1'b1;
      checks++;
      if ({done1_b, done0_b} !== exp_done) begin
        errors++; $display("FAIL guard0_done cyc=%0d: got %b want %b", cyc, {done1_b, done0_b}, exp_done);
      end
      if (exp_done != 2'b00) begin
        in_frame = 1'b0; n_done++; next_ok = cyc + 1;
        $display("guard0: done%0d cyc=%0d", cur, cyc);
        checks++;
        if (busy_b !== 1'b0) begin errors++; $display("FAIL guard0_idle: got %b want 0", busy_b); end
        checks++;
        if (rx_enable_b !== 1'b1) begin errors++; $display("FAIL guard0_rx: got %b want 1", rx_enable_b); end
      end
      checks++;
      if ({fail0_b, fail1_b} !== 2'b00) begin errors++; $display("FAIL guard0_fail: got %b want 00", {fail0_b, fail1_b}); end
    end
    checks++;
    if (n_done !== 3) begin errors++; $display("FAIL guard0_frames: got %0d want 3", n_done); end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_send();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_guard_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
